// File: rtl/kyber_ct_byte_tx.sv
`default_nettype none
// ============================================================================
// Module   : kyber_ct_byte_tx
// Purpose  : Packs compressed Kyber ciphertext coefficients (u then v) into
//            little-endian bytes and streams them out through a byte FIFO.
//            Define KYBER_CT_CHECKSUM_EN to add the ct_xor running checksum.
// Revision : 1.0 - initial release
// ============================================================================
module kyber_ct_byte_tx #(
    parameter int DEPTH = 8,
    parameter int K     = 3,
    parameter int DU    = 10,
    parameter int DV    = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        set,
    input  logic [15:0] comp_din,
    input  logic        comp_valid,
    output logic        comp_ready,
    input  logic        readout,
    output logic        readout_ok,
    output logic [7:0]  kyber_dout,
    output logic [15:0] kyber_out_index,
    output logic [3:0]  output_type,
    output logic        full_out,
`ifdef KYBER_CT_CHECKSUM_EN
    output logic [7:0]  ct_xor,
`endif
    output logic        done
);

    localparam int          AW        = $clog2(DEPTH);
    localparam logic [AW:0] C_DEPTH   = DEPTH[AW:0];
    localparam logic [15:0] C_U_COEFS = 16'(K * 256);
    localparam logic [15:0] C_V_COEFS = 16'd256;
    localparam logic [15:0] C_U_BYTES = 16'(K * 32 * DU);
    localparam logic [15:0] C_TOTAL   = 16'(K * 32 * DU + 32 * DV);
    localparam logic [15:0] C_MASK_U  = 16'((32'd1 << DU) - 32'd1);
    localparam logic [15:0] C_MASK_V  = 16'((32'd1 << DV) - 32'd1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_PACK_U = 3'd1,
        S_PACK_V = 3'd2,
        S_DRAIN  = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    state_t        state_q, state_d;
    logic [23:0]   acc_q, acc_d;
    logic [4:0]    acc_cnt_q, acc_cnt_d;
    logic [15:0]   coef_cnt_q, coef_cnt_d;
    logic [15:0]   push_cnt_q, push_cnt_d;
    logic [15:0]   idx_q, idx_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   fcnt_q, fcnt_d;
    logic          comp_ready_q, comp_ready_d;
    logic          done_q;
    // Each entry: bit 8 marks a v byte, bits 7:0 the ciphertext byte.
    logic [8:0]    mem_q [DEPTH];
`ifdef KYBER_CT_CHECKSUM_EN
    logic [7:0]    ct_xor_q, ct_xor_d;
`endif

    logic          w_pack_q, w_pack_d, w_accept, w_emit, w_pop;
    logic [4:0]    w_width;
    logic [15:0]   w_coef;
    logic [8:0]    w_head;

    assign w_pack_q = (state_q == S_PACK_U) || (state_q == S_PACK_V);
    assign w_pack_d = (state_d == S_PACK_U) || (state_d == S_PACK_V);
    assign w_width  = (state_q == S_PACK_V) ? 5'(DV) : 5'(DU);
    assign w_coef   = comp_din & ((state_q == S_PACK_V) ? C_MASK_V : C_MASK_U);
    assign w_accept = comp_valid && comp_ready_q;
    assign w_emit   = (w_pack_q || (state_q == S_DRAIN)) && (acc_cnt_q >= 5'd8)
                      && (fcnt_q != C_DEPTH);
    assign w_pop    = readout && (fcnt_q != '0);
    assign w_head   = mem_q[rd_ptr_q];

    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        acc_cnt_d  = acc_cnt_q;
        coef_cnt_d = coef_cnt_q;
        push_cnt_d = push_cnt_q;
        idx_d      = idx_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        fcnt_d     = fcnt_q;
`ifdef KYBER_CT_CHECKSUM_EN
        ct_xor_d   = ct_xor_q;
`endif

        // comp_ready is only high while acc_cnt < 8, so accept excludes emit.
        if (w_accept) begin
            acc_d     = acc_q | (24'(w_coef) << acc_cnt_q);
            acc_cnt_d = acc_cnt_q + w_width;
        end else if (w_emit) begin
            acc_d     = acc_q >> 8;
            acc_cnt_d = acc_cnt_q - 5'd8;
        end

        if (w_emit) begin
            wr_ptr_d   = wr_ptr_q + 1'b1;
            push_cnt_d = push_cnt_q + 16'd1;
        end
        if (w_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
            idx_d    = idx_q + 16'd1;
`ifdef KYBER_CT_CHECKSUM_EN
            ct_xor_d = ct_xor_q ^ w_head[7:0];
`endif
        end
        case ({w_emit, w_pop})
            2'b10:   fcnt_d = fcnt_q + 1'b1;
            2'b01:   fcnt_d = fcnt_q - 1'b1;
            default: fcnt_d = fcnt_q;
        endcase

        case (state_q)
            S_IDLE: begin
                acc_d      = '0;
                acc_cnt_d  = '0;
                coef_cnt_d = '0;
                push_cnt_d = '0;
                idx_d      = '0;
                wr_ptr_d   = '0;
                rd_ptr_d   = '0;
                fcnt_d     = '0;
`ifdef KYBER_CT_CHECKSUM_EN
                ct_xor_d   = '0;
`endif
                if (set) state_d = S_PACK_U;
            end
            S_PACK_U: begin
                if (w_accept) begin
                    if (coef_cnt_q == C_U_COEFS - 16'd1) begin
                        state_d    = S_PACK_V;
                        coef_cnt_d = '0;
                    end else begin
                        coef_cnt_d = coef_cnt_q + 16'd1;
                    end
                end
            end
            S_PACK_V: begin
                if (w_accept) begin
                    if (coef_cnt_q == C_V_COEFS - 16'd1) begin
                        state_d    = S_DRAIN;
                        coef_cnt_d = '0;
                    end else begin
                        coef_cnt_d = coef_cnt_q + 16'd1;
                    end
                end
            end
            S_DRAIN: begin
                if (idx_d == C_TOTAL) state_d = S_DONE;
            end
            S_DONE: begin
                if (!set) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        comp_ready_d = w_pack_q && w_pack_d && (acc_cnt_d < 5'd8);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            acc_q        <= '0;
            acc_cnt_q    <= '0;
            coef_cnt_q   <= '0;
            push_cnt_q   <= '0;
            idx_q        <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            fcnt_q       <= '0;
            comp_ready_q <= 1'b0;
            done_q       <= 1'b0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
`ifdef KYBER_CT_CHECKSUM_EN
            ct_xor_q     <= '0;
`endif
        end else begin
            state_q      <= state_d;
            acc_q        <= acc_d;
            acc_cnt_q    <= acc_cnt_d;
            coef_cnt_q   <= coef_cnt_d;
            push_cnt_q   <= push_cnt_d;
            idx_q        <= idx_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            fcnt_q       <= fcnt_d;
            comp_ready_q <= comp_ready_d;
            done_q       <= (state_d == S_DONE);
            if (w_emit) mem_q[wr_ptr_q] <= {(push_cnt_q >= C_U_BYTES), acc_q[7:0]};
`ifdef KYBER_CT_CHECKSUM_EN
            ct_xor_q     <= ct_xor_d;
`endif
        end
    end

    assign comp_ready      = comp_ready_q;
    assign readout_ok      = (fcnt_q != '0);
    assign kyber_dout      = readout_ok ? w_head[7:0] : 8'h00;
    assign kyber_out_index = idx_q;
    assign output_type     = !readout_ok ? 4'd0 : (w_head[8] ? 4'd2 : 4'd1);
    assign full_out        = readout_ok && (idx_q == C_TOTAL - 16'd1);
    assign done            = done_q;
`ifdef KYBER_CT_CHECKSUM_EN
    assign ct_xor          = ct_xor_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_kyber_ct_byte_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_kyber_ct_byte_tx
// Purpose  : Scoreboard bench for kyber_ct_byte_tx (default parameters).
// Revision : 1.0 - initial release
// ============================================================================
module tb_kyber_ct_byte_tx;

    localparam int DEPTH   = 8;
    localparam int U_N     = 768;
    localparam int U_BYTES = 960;
    localparam int TOTAL   = 1088;

    logic        clk = 1'b0;
    logic        reset, set, comp_valid, readout;
    logic [15:0] comp_din;
    logic        comp_ready, readout_ok, full_out, done;
    logic [7:0]  kyber_dout;
    logic [15:0] kyber_out_index;
    logic [3:0]  output_type;
`ifdef KYBER_CT_CHECKSUM_EN
    logic [7:0]  ct_xor;
`endif

    kyber_ct_byte_tx #(.DEPTH(DEPTH), .K(3), .DU(10), .DV(4)) dut (
        .clk             (clk),
        .reset           (reset),
        .set             (set),
        .comp_din        (comp_din),
        .comp_valid      (comp_valid),
        .comp_ready      (comp_ready),
        .readout         (readout),
        .readout_ok      (readout_ok),
        .kyber_dout      (kyber_dout),
        .kyber_out_index (kyber_out_index),
        .output_type     (output_type),
        .full_out        (full_out),
`ifdef KYBER_CT_CHECKSUM_EN
        .ct_xor          (ct_xor),
`endif
        .done            (done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0]  b;
        logic [15:0] idx;
        logic [3:0]  typ;
        logic        full;
    } exp_t;

    exp_t        exp_q[$];
    logic [7:0]  got_mem [TOTAL];
    logic [3:0]  got_typ [TOTAL];
    int          n_cmp = 0;
    int          n_fail = 0;
    bit          abort = 1'b0;
    bit          chk_done_next = 1'b0;
    logic [31:0] m_acc;
    int          m_cnt, m_idx;
    logic [7:0]  m_xor;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    // Reference packer: bytes go to the scoreboard once their coefficient is accepted.
    function automatic void model_push(input logic [15:0] v, input bit is_v);
        int          w = is_v ? 4 : 10;
        logic [31:0] mv = 32'(v) & ((32'd1 << w) - 32'd1);
        exp_t        e;
        m_acc = m_acc | (mv << m_cnt);
        m_cnt = m_cnt + w;
        while (m_cnt >= 8) begin
            e.b    = m_acc[7:0];
            e.idx  = 16'(m_idx);
            e.typ  = (m_idx < U_BYTES) ? 4'd1 : 4'd2;
            e.full = (m_idx == TOTAL - 1);
            exp_q.push_back(e);
            m_xor  = m_xor ^ m_acc[7:0];
            m_acc  = m_acc >> 8;
            m_cnt  = m_cnt - 8;
            m_idx++;
        end
    endfunction

    function automatic logic [15:0] coef(input int mode, input int i, input bit is_v);
        case (mode)
            1: begin
                if (!is_v) return (i < 4) ? 16'(i + 1) : 16'h0;
                return (i == 0) ? 16'h5 : ((i == 1) ? 16'hA : 16'h0);
            end
            2: return is_v ? (16'h0F0 | 16'(i & 15)) : 16'hFFFF;
            default: return 16'h0;
        endcase
    endfunction

    task automatic send_coef(input logic [15:0] v, input bit is_v);
        int t = 0;
        comp_din   = v;
        comp_valid = 1'b1;
        while (!abort) begin
            @(negedge clk);
            if (comp_ready) break;
            t++;
            if (t > 2000) begin
                n_cmp++;
                n_fail++;
                $display("FAIL coef_timeout: comp_ready low for %0d cycles, expected high", t);
                abort = 1'b1;
            end
        end
        if (!abort) begin
            @(posedge clk);
            #1;
            model_push(v, is_v);
        end
        comp_valid = 1'b0;
    endtask

    task automatic run(input int mode);
        int t = 0;
        m_acc = '0; m_cnt = 0; m_idx = 0; m_xor = '0;
        @(posedge clk);
        #1 set = 1'b1;
        for (int i = 0; i < U_N && !abort; i++) send_coef(coef(mode, i, 1'b0), 1'b0);
        for (int i = 0; i < 256 && !abort; i++) send_coef(coef(mode, i, 1'b1), 1'b1);
        if (!abort) begin
            while (!done && t < 4000) begin
                @(negedge clk);
                t++;
            end
            check("done_reached", 32'(done), 32'd1);
            check("queue_drained", 32'(exp_q.size()), 32'd0);
`ifdef KYBER_CT_CHECKSUM_EN
            check("ct_xor", 32'(ct_xor), 32'(m_xor));
`endif
            repeat (3) @(negedge clk);
            check("done_held", 32'(done), 32'd1);
`ifdef KYBER_CT_CHECKSUM_EN
            check("ct_xor_held", 32'(ct_xor), 32'(m_xor));
`endif
        end
        @(posedge clk);
        #1 set = 1'b0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    // Monitor: compares every transferred byte against the scoreboard head.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (chk_done_next) begin
                check("done_after_last", 32'(done), 32'd1);
                chk_done_next = 1'b0;
            end
            if (readout && readout_ok && !reset) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL unexpected_byte: got byte at index %0d, none expected", kyber_out_index);
                end else begin
                    e = exp_q.pop_front();
                    check("byte_idx_type_full",
                          32'({kyber_dout, kyber_out_index, output_type, full_out}), 32'(e));
                    if (e.full) begin
                        check("done_low_at_last", 32'(done), 32'd0);
                        chk_done_next = 1'b1;
                    end
                    if (kyber_out_index < 16'(TOTAL)) begin
                        got_mem[kyber_out_index] = kyber_dout;
                        got_typ[kyber_out_index] = output_type;
                    end
                end
            end
        end
    end

    initial begin
        int cnt;
        reset = 1'b1; set = 1'b0; comp_valid = 1'b0; comp_din = '0; readout = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", 32'({comp_ready, readout_ok, kyber_dout, kyber_out_index,
                                    output_type, full_out, done}), 32'd0);
        reset = 1'b0;

        // comp_valid in IDLE must not be taken
        comp_valid = 1'b1; comp_din = 16'h1234;
        repeat (5) @(posedge clk);
        #1;
        check("idle_comp_ready", 32'(comp_ready), 32'd0);
        check("idle_readout_ok", 32'(readout_ok), 32'd0);
        comp_valid = 1'b0;

        run(0);
        cnt = 0;
        for (int i = 0; i < TOTAL; i++) if (got_mem[i] == 8'h00) cnt++;
        check("all_zero_bytes", 32'(cnt), 32'(TOTAL));

        // Backpressure: host stalled while the coefficient side fills the FIFO.
        readout = 1'b0;
        fork
            run(2);
            begin
                repeat (200) @(negedge clk);
                check("bp_comp_ready_low", 32'(comp_ready), 32'd0);
                check("bp_head", 32'({readout_ok, kyber_dout, kyber_out_index, output_type}),
                      32'({1'b1, 8'hFF, 16'd0, 4'd1}));
                repeat (20) @(negedge clk);
                check("bp_still_stalled", 32'(comp_ready), 32'd0);
                check("bp_head_stable", 32'({readout_ok, kyber_dout, kyber_out_index, output_type}),
                      32'({1'b1, 8'hFF, 16'd0, 4'd1}));
                @(posedge clk);
                #1 readout = 1'b1;
            end
        join
        cnt = 0;
        for (int i = 0; i < U_BYTES; i++) if (got_mem[i] == 8'hFF) cnt++;
        check("u_masked_all_ff", 32'(cnt), 32'(U_BYTES));
        check("v_first_byte", 32'(got_mem[960]), 32'h10);
        check("v_second_byte", 32'(got_mem[961]), 32'h32);
        check("v_last_byte", 32'(got_mem[1087]), 32'hFE);

        // Reset at index 500, then a full rerun of the same pattern.
        fork
            run(1);
            begin
                int t = 0;
                while (kyber_out_index != 16'd500 && t < 5000) begin
                    @(negedge clk);
                    t++;
                end
                check("reached_idx500", 32'(kyber_out_index), 32'd500);
                reset = 1'b1;
                abort = 1'b1;
                #1;
                check("midrun_reset_outputs", 32'({comp_ready, readout_ok, kyber_dout,
                      kyber_out_index, output_type, full_out, done}), 32'd0);
`ifdef KYBER_CT_CHECKSUM_EN
                check("midrun_reset_ct_xor", 32'(ct_xor), 32'd0);
`endif
            end
        join
        exp_q.delete();
        chk_done_next = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        abort = 1'b0;
        set = 1'b0;
        repeat (2) @(posedge clk);
        run(1);
        check("u_byte0", 32'(got_mem[0]), 32'h01);
        check("u_byte1", 32'(got_mem[1]), 32'h08);
        check("u_byte2", 32'(got_mem[2]), 32'h30);
        check("u_byte3", 32'(got_mem[3]), 32'h00);
        check("u_byte4", 32'(got_mem[4]), 32'h01);
        check("u_type0", 32'(got_typ[0]), 32'd1);
        check("v_byte960", 32'(got_mem[960]), 32'hA5);
        check("v_type960", 32'(got_typ[960]), 32'd2);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
